// File: rtl/sprite_pkg.sv
// Constants and types for the sprite line scheduler: VGA 640x480 timing,
// 64x48 sprite geometry, 3-3-2 pixel format and the fetch state encoding.
package sprite_pkg;
   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [9:0] H_TOTAL  = 10'd800;
   localparam logic [9:0] V_ACTIVE = 10'd480;
   localparam logic [9:0] V_TOTAL  = 10'd525;
   localparam logic [9:0] SPR_W    = 10'd64;
   localparam logic [9:0] SPR_H    = 10'd48;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   localparam rgb332_t KEY = 8'b111_000_11;

   typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, DRAIN} state_t;

   // Sprite rows are SPR_W wide, so the ROM address is just {row, col}.
   function automatic logic [11:0] sprite_addr(input logic [5:0] row, input logic [5:0] col);
      return {row, col};
   endfunction
endpackage

// File: rtl/sprite_line_sched_if.sv
// Raster, position, ROM-port and composite-pixel signals of the sprite line scheduler.
// master = scheduler side, slave = raster/ROM/colour-mux side.
interface sprite_line_sched_if;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic [9:0]  p1_x;
   logic [9:0]  p1_y;
   logic [9:0]  p2_x;
   logic [9:0]  p2_y;
   logic        rom_en;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        which;
   logic        rom_bank;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic        hit;
   logic        busy;
   logic        overrun;

   modport master (
      input  hc, vc, p1_x, p1_y, p2_x, p2_y, rom_data, which,
      output rom_en, rom_addr, rom_bank, red, green, blue, hit, busy, overrun
   );

   modport slave (
      output hc, vc, p1_x, p1_y, p2_x, p2_y, rom_data, which,
      input  rom_en, rom_addr, rom_bank, red, green, blue, hit, busy, overrun
   );
endinterface

// File: rtl/sprite_line_buf.sv
// 64 x 3-3-2 sprite row store: one synchronous write port, one combinational read port.
// Written only during horizontal blanking; contents are don't-care until a fetch completes.
module sprite_line_buf
   import sprite_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  logic [5:0] waddr,
   input  rgb332_t    wdat,
   input  logic [5:0] raddr,
   output rgb332_t    rdat
);
   rgb332_t mem_q [64];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdat;
   end

   assign rdat = mem_q[raddr];
endmodule

// File: rtl/sprite_line_sched.sv
// Shares one sprite ROM between two players: hblank prefetch of next-line rows, then a
// registered P1-over-P2 composite with colour-key transparency. Pixel latency 1; no backpressure.
module sprite_line_sched
   import sprite_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   sprite_line_sched_if.master io
);
   state_t     state_q, state_d;
   logic [5:0] col_q, col_d;
   logic [9:0] x1_q, x1_d, x2_q, x2_d;
   logic [5:0] row1_q, row1_d, row2_q, row2_d;
   logic       on1_q, on1_d, on2_q, on2_d;
   logic       flag1_q, flag1_d, flag2_q, flag2_d;
   logic       overrun_q, overrun_d;
   logic       cap_vld_q, cap_vld_d, cap_bank_q, cap_bank_d;
   logic [5:0] cap_col_q, cap_col_d;
   rgb332_t    pix_q, pix_d;
   logic       hit_q, hit_d;

   logic [9:0] nl, r1, r2, c1, c2;
   logic       on1, on2, fetching, bank;
   rgb332_t    rd1, rd2;

   // Next line wraps to 0 after the last line of the frame.
   assign nl  = (io.vc == V_TOTAL - 10'd1) ? 10'd0 : io.vc + 10'd1;
   assign r1  = nl - io.p1_y;
   assign r2  = nl - io.p2_y;
   assign on1 = (nl >= io.p1_y) && (r1 < SPR_H);
   assign on2 = (nl >= io.p2_y) && (r2 < SPR_H);

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      row1_d    = row1_q;
      row2_d    = row2_q;
      on1_d     = on1_q;
      on2_d     = on2_q;
      flag1_d   = flag1_q;
      flag2_d   = flag2_q;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (io.hc == H_ACTIVE) begin
               x1_d    = io.p1_x;
               x2_d    = io.p2_x;
               row1_d  = r1[5:0];
               row2_d  = r2[5:0];
               on1_d   = on1;
               on2_d   = on2;
               flag1_d = 1'b0;
               flag2_d = 1'b0;
               col_d   = 6'd0;
               if (on1)      state_d = FETCH1;
               else if (on2) state_d = FETCH2;
            end
         end
         FETCH1: begin
            col_d = col_q + 6'd1;
            if (&col_q) state_d = on2_q ? FETCH2 : DRAIN;
         end
         FETCH2: begin
            col_d = col_q + 6'd1;
            if (&col_q) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = IDLE;
            flag1_d = on1_q;
            flag2_d = on2_q;
         end
         default: state_d = IDLE;
      endcase
      // A fetch still running at end of line would corrupt the next line: drop it.
      if (state_q != IDLE && io.hc == H_TOTAL - 10'd1) begin
         state_d   = IDLE;
         flag1_d   = 1'b0;
         flag2_d   = 1'b0;
         overrun_d = 1'b1;
      end
   end

   assign fetching    = (state_q == FETCH1) || (state_q == FETCH2);
   assign bank        = (state_q == FETCH2);
   assign io.rom_en   = fetching;
   assign io.rom_bank = bank;
   assign io.rom_addr = fetching ? sprite_addr(bank ? row2_q : row1_q, col_q) : 12'd0;

   // ROM data arrives one cycle after the read, so column and bank travel alongside.
   assign cap_vld_d  = fetching;
   assign cap_bank_d = bank;
   assign cap_col_d  = col_q;

   assign c1 = io.hc - x1_q;
   assign c2 = io.hc - x2_q;

   sprite_line_buf u_buf1 (
      .clk   (clk),
      .we    (cap_vld_q && !cap_bank_q),
      .waddr (cap_col_q),
      .wdat  (io.rom_data),
      .raddr (c1[5:0]),
      .rdat  (rd1)
   );

   sprite_line_buf u_buf2 (
      .clk   (clk),
      .we    (cap_vld_q && cap_bank_q),
      .waddr (cap_col_q),
      .wdat  (io.rom_data),
      .raddr (c2[5:0]),
      .rdat  (rd2)
   );

   always_comb begin
      pix_d = '0;
      hit_d = 1'b0;
      if (io.hc < H_ACTIVE && io.vc < V_ACTIVE) begin
         if (flag1_q && c1 < SPR_W && rd1 != KEY) begin
            pix_d = rd1;
            hit_d = 1'b1;
         end else if (flag2_q && c2 < SPR_W && rd2 != KEY) begin
            pix_d = rd2;
            hit_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         col_q      <= '0;
         x1_q       <= '0;
         x2_q       <= '0;
         row1_q     <= '0;
         row2_q     <= '0;
         on1_q      <= 1'b0;
         on2_q      <= 1'b0;
         flag1_q    <= 1'b0;
         flag2_q    <= 1'b0;
         overrun_q  <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_bank_q <= 1'b0;
         cap_col_q  <= '0;
         pix_q      <= '0;
         hit_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
         row1_q     <= row1_d;
         row2_q     <= row2_d;
         on1_q      <= on1_d;
         on2_q      <= on2_d;
         flag1_q    <= flag1_d;
         flag2_q    <= flag2_d;
         overrun_q  <= overrun_d;
         cap_vld_q  <= cap_vld_d;
         cap_bank_q <= cap_bank_d;
         cap_col_q  <= cap_col_d;
         pix_q      <= pix_d;
         hit_q      <= hit_d;
      end
   end

   assign io.red     = pix_q.r;
   assign io.green   = pix_q.g;
   assign io.blue    = pix_q.b;
   assign io.hit     = hit_q;
   assign io.busy    = (state_q != IDLE);
   assign io.overrun = overrun_q;
endmodule
